gate_share_arbiter: RTL and testbench



---
 rtl/gate_share_pkg.sv | 22 ++
 rtl/gate_eval_unit.sv | 29 ++
 rtl/gate_share_arbiter.sv | 158 +++++++++++++++
 tb/tb_gate_share_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_share_pkg.sv
// ---------------------------------------------------------------------------
// gate_share_pkg : opcode and FSM state encodings for gate_share_arbiter.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gate_share_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_NOR = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/gate_eval_unit.sv
// ---------------------------------------------------------------------------
// gate_eval_unit : combinational 2-input AND/OR/NOR/XOR evaluator.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gate_eval_unit
  import gate_share_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] op,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      default: y = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/gate_share_arbiter.sv
// ---------------------------------------------------------------------------
// gate_share_arbiter : round-robin sharing of one gate evaluator among N_REQ
// requesters. Optional GATE_SHARE_STATS_EN adds op_cnt/busy.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gate_share_arbiter
  import gate_share_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   a,
  input  logic [N_REQ-1:0]   b,
  input  logic [2*N_REQ-1:0] op,
  output logic [N_REQ-1:0]   gnt,
  output logic               vld,
  output logic               y,
  output logic [ID_W-1:0]    id
`ifdef GATE_SHARE_STATS_EN
  ,
  output logic [15:0]        op_cnt,
  output logic               busy
`endif
);

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              vld_q, vld_d;
  logic              y_q, y_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              a_q, a_d;
  logic              b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [ID_W-1:0]   winner;
  logic              eval_y;

  // Rotate so bit 0 is the pointer position, then take the lowest set bit.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [ID_W-1:0]  p);
    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0]  w;
    logic             found;
    rot   = (r >> p) | (r << (N_REQ - int'(p)));
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        w     = ID_W'((int'(p) + k) % N_REQ);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign winner = rr_pick(req, ptr_q);

  gate_eval_unit u_eval (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (eval_y)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    y_d     = y_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          a_d     = 1'(a >> winner);
          b_d     = 1'(b >> winner);
          op_d    = 2'(op >> {winner, 1'b0});
          gnt_d   = N_REQ'(1) << winner;
          id_d    = winner;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        y_d     = eval_y;
        gnt_d   = '0;
        vld_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        vld_d   = 1'b0;
        ptr_d   = ID_W'((int'(id_q) + 1) % N_REQ);
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        vld_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef GATE_SHARE_STATS_EN
  logic [15:0] op_cnt_q, op_cnt_d;

  always_comb begin
    op_cnt_d = op_cnt_q;
    if (state_q == S_DONE) op_cnt_d = op_cnt_q + 16'd1;
  end

  assign op_cnt = op_cnt_q;
  assign busy   = (state_q != S_IDLE);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      vld_q    <= 1'b0;
      y_q      <= 1'b0;
      id_q     <= '0;
      ptr_q    <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      op_q     <= 2'b00;
`ifdef GATE_SHARE_STATS_EN
      op_cnt_q <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      vld_q    <= vld_d;
      y_q      <= y_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
`ifdef GATE_SHARE_STATS_EN
      op_cnt_q <= op_cnt_d;
`endif
    end
  end

  assign gnt = gnt_q;
  assign vld = vld_q;
  assign y   = y_q;
  assign id  = id_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gate_share_arbiter : directed vectors and sequences for gate_share_arbiter.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gate_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, a, b;
  logic [7:0] op;
  logic [3:0] gnt;
  logic       vld, y;
  logic [1:0] id;
`ifdef GATE_SHARE_STATS_EN
  logic [15:0] op_cnt;
  logic        busy;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gate_share_arbiter #(.N_REQ(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .a      (a),
    .b      (b),
    .op     (op),
    .gnt    (gnt),
    .vld    (vld),
    .y      (y),
    .id     (id)
`ifdef GATE_SHARE_STATS_EN
    ,
    .op_cnt (op_cnt),
    .busy   (busy)
`endif
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] op;
    logic [3:0] egnt;
    logic [1:0] eid;
    logic       ey;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (gnt != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit ok;
    req = v.req; a = v.a; b = v.b; op = v.op;
    wait_gnt(ok);
    if (ok) begin
      check($sformatf("vec%0d_gnt", idx), 32'(gnt), 32'(v.egnt));
      req = 4'b0000;
      @(negedge clk);
      check($sformatf("vec%0d_vld", idx), 32'(vld), 32'd1);
      check($sformatf("vec%0d_id", idx), 32'(id), 32'(v.eid));
      check($sformatf("vec%0d_y", idx), 32'(y), 32'(v.ey));
      @(negedge clk);
      check($sformatf("vec%0d_vld_drop", idx), 32'(vld), 32'd0);
    end
    req = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen;
    logic [1:0] rr_y [4];

    //             req      a        b        op     egnt     id    y
    tbl[0]  = '{4'b0100, 4'b0100, 4'b0000, 8'h00, 4'b0100, 2'd2, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0100, 4'b0000, 8'h10, 4'b0100, 2'd2, 1'b1};
    tbl[2]  = '{4'b0100, 4'b0100, 4'b0000, 8'h20, 4'b0100, 2'd2, 1'b0};
    tbl[3]  = '{4'b0100, 4'b0100, 4'b0000, 8'h30, 4'b0100, 2'd2, 1'b1};
    tbl[4]  = '{4'b0001, 4'b0001, 4'b0001, 8'h00, 4'b0001, 2'd0, 1'b1};
    tbl[5]  = '{4'b1000, 4'b0000, 4'b0000, 8'h80, 4'b1000, 2'd3, 1'b1};
    tbl[6]  = '{4'b0010, 4'b0010, 4'b0010, 8'h0C, 4'b0010, 2'd1, 1'b0};
    tbl[7]  = '{4'b0001, 4'b0000, 4'b0001, 8'h01, 4'b0001, 2'd0, 1'b1};
    tbl[8]  = '{4'b1001, 4'b1000, 4'b0000, 8'h00, 4'b1000, 2'd3, 1'b0};
    tbl[9]  = '{4'b1001, 4'b0000, 4'b0000, 8'h02, 4'b0001, 2'd0, 1'b1};
    tbl[10] = '{4'b0110, 4'b0010, 4'b0000, 8'h08, 4'b0010, 2'd1, 1'b0};
    tbl[11] = '{4'b0011, 4'b0001, 4'b0001, 8'h03, 4'b0001, 2'd0, 1'b0};

    rr_y[0] = 2'd1; rr_y[1] = 2'd1; rr_y[2] = 2'd0; rr_y[3] = 2'd0;

    rst_n = 1'b0; req = '0; a = '0; b = '0; op = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_vld", 32'(vld), 32'd0);
    check("rst_y",   32'(y),   32'd0);
    check("rst_id",  32'(id),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // All requesters held: AND(1,1)=1, OR(0,1)=1, NOR(1,0)=0, XOR(0,0)=0.
    req = 4'b1111; a = 4'b0101; b = 4'b0011; op = 8'hE4;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(ok);
      if (ok) begin
        check($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
        @(negedge clk);
        check($sformatf("rr%0d_gnt_drop", k), 32'(gnt), 32'd0);
        check($sformatf("rr%0d_vld", k), 32'(vld), 32'd1);
        check($sformatf("rr%0d_id", k), 32'(id), 32'(k % 4));
        check($sformatf("rr%0d_y", k), 32'(y), 32'(rr_y[k % 4][0]));
      end
    end
    req = 4'b0000;
    @(negedge clk);
    check("rr_vld_drop", 32'(vld), 32'd0);

    for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

    // Operand change after sampling must not affect the result.
    req = 4'b0010; a = 4'b0010; b = 4'b0010; op = 8'h00;
    wait_gnt(ok);
    if (ok) begin
      a = 4'b0000;
      req = 4'b0000;
      @(negedge clk);
      check("hold_vld", 32'(vld), 32'd1);
      check("hold_y",   32'(y),   32'd1);
      @(negedge clk);
    end

    // Reset while in EVAL: everything clears and the op never completes.
    req = 4'b1000; a = 4'b0000; b = 4'b0000; op = 8'h80;
    wait_gnt(ok);
    if (ok) begin
      req = 4'b0000;
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_gnt", 32'(gnt), 32'd0);
      check("midrst_vld", 32'(vld), 32'd0);
      check("midrst_y",   32'(y),   32'd0);
      check("midrst_id",  32'(id),  32'd0);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (vld) seen = 1'b1;
      end
      check("midrst_no_vld", 32'(seen), 32'd0);
    end

    // Pointer is back at 0 after reset.
    req = 4'b1111; a = 4'b0101; b = 4'b0011; op = 8'hE4;
    wait_gnt(ok);
    if (ok) begin
      check("postrst_gnt", 32'(gnt), 32'b0001);
      req = 4'b0000;
      @(negedge clk);
      check("postrst_y", 32'(y), 32'd1);
      @(negedge clk);
    end

`ifdef GATE_SHARE_STATS_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("stats_cnt_rst", 32'(op_cnt), 32'd0);
    check("stats_busy_idle", 32'(busy), 32'd0);
    for (int k = 0; k < 5; k++) begin
      req = 4'b0001; a = 4'b0001; b = 4'b0000; op = 8'h01;
      wait_gnt(ok);
      if (ok) begin
        check($sformatf("stats%0d_busy_eval", k), 32'(busy), 32'd1);
        req = 4'b0000;
        @(negedge clk);
        check($sformatf("stats%0d_busy_done", k), 32'(busy), 32'd1);
        @(negedge clk);
        check($sformatf("stats%0d_busy_idle", k), 32'(busy), 32'd0);
      end
    end
    check("stats_cnt5", 32'(op_cnt), 32'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
